alu_controller: RTL and testbench

ALU_CONTROLLER -- requirements
Module: alu_controller

---
 rtl/alu_controller_pkg.sv | 16 +
 rtl/alu_controller.sv | 99 +++++++++
 tb/tb_alu_controller.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/alu_controller_pkg.sv
// Shared opcode constants and FSM state encoding for alu_controller and the
// external ALU it drives.
package alu_controller_pkg;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_AND = 2'd2;
  localparam logic [1:0] OP_NOT = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu_controller.sv
// Command/response sequencer for an external combinational ALU: owns the
// accumulator, the zero flag and the completed-command count.
module alu_controller
  import alu_controller_pkg::*;
#(
  parameter logic [1:0] ADD = OP_ADD,
  parameter logic [1:0] SUB = OP_SUB,
  parameter logic [1:0] AND = OP_AND,
  parameter logic [1:0] NOT = OP_NOT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmdValid,
  output logic       cmdReady,
  input  logic       cmdLoad,
  input  logic [1:0] cmdOp,
  input  logic [7:0] cmdData,
  output logic [1:0] ALUop,
  output logic [7:0] aluA,
  output logic [7:0] aluB,
  input  logic [7:0] aluRes,
  output logic       rspValid,
  input  logic       rspReady,
  output logic [7:0] rspData,
  output logic       zero,
  output logic [7:0] opCount
);

  state_t     state;
  state_t     next_state;
  logic [7:0] acc;

  // Commands use the package encoding; the ALU may be built with its own codes.
  function automatic logic [1:0] map_op(input logic [1:0] op);
    case (op)
      OP_ADD:  map_op = ADD;
      OP_SUB:  map_op = SUB;
      OP_AND:  map_op = AND;
      default: map_op = NOT;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (cmdValid) next_state = cmdLoad ? RESP : EXEC;
      EXEC:    next_state = RESP;
      RESP:    if (rspReady) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    cmdReady = (state == IDLE);
    rspValid = (state == RESP);
  end

  // Operand registers change only on acceptance, so the ALU inputs hold in IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc     <= 8'd0;
      ALUop   <= 2'd0;
      aluB    <= 8'd0;
      zero    <= 1'b1;
      opCount <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (cmdValid) begin
            if (cmdLoad) begin
              acc  <= cmdData;
              zero <= (cmdData == 8'd0);
            end else begin
              ALUop <= map_op(cmdOp);
              aluB  <= cmdData;
            end
          end
        end
        EXEC: begin
          acc  <= aluRes;
          zero <= (aluRes == 8'd0);
        end
        RESP: begin
          if (rspReady) opCount <= opCount + 8'd1;
        end
        default: ;
      endcase
    end
  end

  assign aluA    = acc;
  assign rspData = acc;

endmodule

// File: tb/tb_alu_controller.sv
// Self-checking bench for alu_controller: table vectors, hand-written corner
// sequences and randomized commands against an arithmetic reference model.
module tb_alu_controller;

  logic       clk;
  logic       rst;
  logic       cmdValid;
  logic       cmdReady;
  logic       cmdLoad;
  logic [1:0] cmdOp;
  logic [7:0] cmdData;
  logic [1:0] ALUop;
  logic [7:0] aluA;
  logic [7:0] aluB;
  logic [7:0] aluRes;
  logic       rspValid;
  logic       rspReady;
  logic [7:0] rspData;
  logic       zero;
  logic [7:0] opCount;

  int checks = 0;
  int fails = 0;
  int overlap_cnt = 0;
  logic [7:0] model_acc = 8'd0;
  int model_count = 0;

  typedef struct {
    logic       ld;
    logic [1:0] op;
    logic [7:0] data;
    int         hold;
    logic [7:0] exp_data;
    logic       exp_zero;
  } vec_t;

  vec_t vecs[11];

  alu_controller dut (
    .clk(clk), .rst(rst),
    .cmdValid(cmdValid), .cmdReady(cmdReady), .cmdLoad(cmdLoad),
    .cmdOp(cmdOp), .cmdData(cmdData),
    .ALUop(ALUop), .aluA(aluA), .aluB(aluB), .aluRes(aluRes),
    .rspValid(rspValid), .rspReady(rspReady), .rspData(rspData),
    .zero(zero), .opCount(opCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Arithmetic as the ALU defines it: 8-bit wrap, logical AND/NOT yield 0 or 1.
  function automatic logic [7:0] ref_alu(input logic [1:0] op, input logic [7:0] a,
                                         input logic [7:0] b);
    case (op)
      2'd0:    ref_alu = a + b;
      2'd1:    ref_alu = a - b;
      2'd2:    ref_alu = (a != 8'd0 && b != 8'd0) ? 8'd1 : 8'd0;
      default: ref_alu = (a == 8'd0) ? 8'd1 : 8'd0;
    endcase
  endfunction

  always_comb aluRes = ref_alu(ALUop, aluA, aluB);

  always @(negedge clk) begin
    if (cmdReady && rspValid) overlap_cnt++;
  end

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic doReset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_acc = 8'd0;
    model_count = 0;
  endtask

  task automatic issueCmd(input logic ld, input logic [1:0] op, input logic [7:0] data);
    int waited;
    int lat;
    logic [7:0] exp;
    waited = 0;
    while (!cmdReady && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("cmd_ready_wait", 8'(cmdReady), 8'd1);
    cmdValid = 1'b1;
    cmdLoad  = ld;
    cmdOp    = op;
    cmdData  = data;
    exp = ld ? data : ref_alu(op, model_acc, data);
    @(posedge clk);
    #1;
    cmdValid = 1'b0;
    cmdLoad  = 1'($urandom);
    cmdOp    = 2'($urandom);
    cmdData  = 8'($urandom);
    @(negedge clk);
    lat = 1;
    if (!ld) begin
      checkOutput("exec_aluop", 8'(ALUop), 8'(op));
      checkOutput("exec_alua", aluA, model_acc);
      checkOutput("exec_alub", aluB, data);
      checkOutput("exec_cmd_ready", 8'(cmdReady), 8'd0);
    end
    while (!rspValid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    model_acc = exp;
    checkOutput("latency", 8'(lat), ld ? 8'd1 : 8'd2);
    checkOutput("rsp_data", rspData, exp);
    checkOutput("rsp_zero", 8'(zero), 8'(exp == 8'd0));
    checkOutput("rsp_cmd_ready", 8'(cmdReady), 8'd0);
  endtask

  task automatic finishRsp(input int hold);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      checkOutput("hold_rsp_valid", 8'(rspValid), 8'd1);
      checkOutput("hold_rsp_data", rspData, model_acc);
      checkOutput("hold_cmd_ready", 8'(cmdReady), 8'd0);
      checkOutput("hold_op_count", opCount, 8'(model_count));
    end
    rspReady = 1'b1;
    @(posedge clk);
    #1 rspReady = 1'b0;
    model_count++;
    @(negedge clk);
    checkOutput("op_count", opCount, 8'(model_count));
    checkOutput("idle_cmd_ready", 8'(cmdReady), 8'd1);
    checkOutput("idle_rsp_valid", 8'(rspValid), 8'd0);
  endtask

  task automatic applyStimulus(input logic ld, input logic [1:0] op, input logic [7:0] data,
                               input int hold, output logic [7:0] rsp, output logic z);
    issueCmd(ld, op, data);
    rsp = rspData;
    z   = zero;
    finishRsp(hold);
  endtask

  initial begin
    logic [7:0] got;
    logic       got_z;
    rst = 1'b1; cmdValid = 1'b0; cmdLoad = 1'b0; cmdOp = 2'd0; cmdData = 8'd0;
    rspReady = 1'b0;

    vecs[0]  = '{1'b1, 2'd0, 8'h05, 0, 8'h05, 1'b0};
    vecs[1]  = '{1'b1, 2'd0, 8'hFF, 0, 8'hFF, 1'b0};
    vecs[2]  = '{1'b0, 2'd0, 8'h02, 1, 8'h01, 1'b0};
    vecs[3]  = '{1'b1, 2'd0, 8'h03, 0, 8'h03, 1'b0};
    vecs[4]  = '{1'b0, 2'd1, 8'h03, 0, 8'h00, 1'b1};
    vecs[5]  = '{1'b0, 2'd3, 8'h9C, 0, 8'h01, 1'b0};
    vecs[6]  = '{1'b0, 2'd2, 8'h00, 0, 8'h00, 1'b1};
    vecs[7]  = '{1'b0, 2'd3, 8'h00, 0, 8'h01, 1'b0};
    vecs[8]  = '{1'b0, 2'd2, 8'h07, 0, 8'h01, 1'b0};
    vecs[9]  = '{1'b0, 2'd1, 8'h02, 2, 8'hFF, 1'b0};
    vecs[10] = '{1'b1, 2'd0, 8'h00, 5, 8'h00, 1'b1};

    doReset();
    @(negedge clk);
    checkOutput("reset_cmd_ready", 8'(cmdReady), 8'd1);
    checkOutput("reset_rsp_valid", 8'(rspValid), 8'd0);
    checkOutput("reset_rsp_data", rspData, 8'd0);
    checkOutput("reset_zero", 8'(zero), 8'd1);
    checkOutput("reset_op_count", opCount, 8'd0);
    checkOutput("reset_alub", aluB, 8'd0);
    checkOutput("reset_aluop", 8'(ALUop), 8'd0);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].ld, vecs[i].op, vecs[i].data, vecs[i].hold, got, got_z);
      checkOutput($sformatf("vec%0d_data", i), got, vecs[i].exp_data);
      checkOutput($sformatf("vec%0d_zero", i), 8'(got_z), 8'(vecs[i].exp_zero));
    end

    // Command offered during the response handshake must wait for IDLE.
    issueCmd(1'b1, 2'd0, 8'h3C);
    rspReady = 1'b1;
    cmdValid = 1'b1; cmdLoad = 1'b1; cmdData = 8'hAA;
    @(posedge clk);
    #1 rspReady = 1'b0;
    model_count++;
    @(negedge clk);
    checkOutput("overlap_cmd_ready", 8'(cmdReady), 8'd1);
    checkOutput("overlap_rsp_valid", 8'(rspValid), 8'd0);
    checkOutput("overlap_acc", rspData, 8'h3C);
    checkOutput("overlap_op_count", opCount, 8'(model_count));
    @(posedge clk);
    #1 cmdValid = 1'b0;
    model_acc = 8'hAA;
    @(negedge clk);
    checkOutput("overlap_late_valid", 8'(rspValid), 8'd1);
    checkOutput("overlap_late_data", rspData, 8'hAA);
    finishRsp(0);

    // Reset while in EXEC discards the command.
    cmdValid = 1'b1; cmdLoad = 1'b0; cmdOp = 2'd0; cmdData = 8'h11;
    @(posedge clk);
    #1 cmdValid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    model_acc = 8'd0;
    model_count = 0;
    @(negedge clk);
    checkOutput("exec_rst_cmd_ready", 8'(cmdReady), 8'd1);
    checkOutput("exec_rst_acc", rspData, 8'd0);
    checkOutput("exec_rst_op_count", opCount, 8'd0);
    checkOutput("exec_rst_zero", 8'(zero), 8'd1);
    for (int i = 0; i < 3; i++) begin
      checkOutput("exec_rst_no_rsp", 8'(rspValid), 8'd0);
      @(negedge clk);
    end

    for (int i = 0; i < 40; i++) begin
      applyStimulus(1'($urandom_range(0, 3) == 0), 2'($urandom), 8'($urandom),
                    int'($urandom_range(0, 2)), got, got_z);
    end

    doReset();
    for (int i = 0; i < 256; i++) begin
      applyStimulus(1'b1, 2'd0, 8'(i), 0, got, got_z);
    end
    checkOutput("wrap_op_count", opCount, 8'd0);
    checkOutput("ready_valid_overlap", 8'(overlap_cnt), 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
